// File: rtl/bip_control_unit_if.sv
// Bus bundle between the BIP control unit and its program memory, data memory and datapath.
interface bip_control_unit_if #(
  parameter int unsigned PC_W = 11
);
  logic [15:0]     instr;
  logic            imem_rd;
  logic [PC_W-1:0] pc_addr;
  logic [10:0]     operand;
  logic            dmem_rd;
  logic            dmem_wr;
  logic [1:0]      set_a;
  logic            set_b;
  logic            op;
  logic            wr_acc;

  modport master (
    input  instr,
    output imem_rd, pc_addr, operand, dmem_rd, dmem_wr, set_a, set_b, op, wr_acc
  );

  modport slave (
    output instr,
    input  imem_rd, pc_addr, operand, dmem_rd, dmem_wr, set_a, set_b, op, wr_acc
  );
endinterface

// File: rtl/bip_control_unit.sv
// BIP control unit: multicycle fetch/decode/execute sequencer driving the accumulator datapath.
// Strobes and selects are decoded combinationally from state so an async reset removes them at once.
module bip_control_unit #(
  parameter int unsigned PC_W  = 11,
  parameter int unsigned RET_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  bip_control_unit_if.master bus,
  output logic               busy,
  output logic               halted,
  output logic [RET_W-1:0]   retired
);

  localparam int unsigned OPC_W = 5;

  localparam logic [OPC_W-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_W-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_W-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_W-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_W-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_W-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_W-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_W-1:0] OPC_SUBI = 5'b00111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [PC_W-1:0]  pc;
  logic [15:0]      ir;
  logic [OPC_W-1:0] opc;
  logic             retire;

  // Fresh instruction word is only on the bus during DECODE; EXEC works from the latched copy.
  assign opc         = (state == S_DECODE) ? bus.instr[15:11] : ir[15:11];
  assign bus.pc_addr = pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_DECODE;
      S_DECODE: begin
        case (opc)
          OPC_HLT:                 state_nxt = S_HALT;
          OPC_LD, OPC_ADD, OPC_SUB: state_nxt = S_EXEC;
          default:                 state_nxt = S_FETCH;
        endcase
      end
      S_EXEC:   state_nxt = S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.imem_rd = 1'b0;
    bus.dmem_rd = 1'b0;
    bus.dmem_wr = 1'b0;
    bus.set_a   = 2'b00;
    bus.set_b   = 1'b0;
    bus.op      = 1'b0;
    bus.wr_acc  = 1'b0;
    bus.operand = ir[10:0];
    retire      = 1'b0;
    busy        = (state == S_FETCH) || (state == S_DECODE) || (state == S_EXEC);
    halted      = (state == S_HALT);
    case (state)
      S_FETCH: bus.imem_rd = 1'b1;
      S_DECODE: begin
        bus.operand = bus.instr[10:0];
        case (opc)
          OPC_HLT: begin
          end
          OPC_STO: begin
            bus.dmem_wr = 1'b1;
            retire      = 1'b1;
          end
          OPC_LD, OPC_ADD, OPC_SUB: bus.dmem_rd = 1'b1;
          OPC_LDI: begin
            bus.set_a  = 2'b01;
            bus.wr_acc = 1'b1;
            retire     = 1'b1;
          end
          OPC_ADDI: begin
            bus.set_a  = 2'b10;
            bus.set_b  = 1'b1;
            bus.op     = 1'b1;
            bus.wr_acc = 1'b1;
            retire     = 1'b1;
          end
          OPC_SUBI: begin
            bus.set_a  = 2'b10;
            bus.set_b  = 1'b1;
            bus.wr_acc = 1'b1;
            retire     = 1'b1;
          end
          default: retire = 1'b1;
        endcase
      end
      S_EXEC: begin
        bus.wr_acc = 1'b1;
        retire     = 1'b1;
        case (opc)
          OPC_ADD: begin
            bus.set_a = 2'b10;
            bus.op    = 1'b1;
          end
          OPC_SUB: bus.set_a = 2'b10;
          default: begin
          end
        endcase
      end
      default: begin
      end
    endcase
  end

  // Restart from HALT rewinds the program; retired count saturates instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc      <= '0;
      ir      <= '0;
      retired <= '0;
    end else begin
      if (state == S_DECODE) ir <= bus.instr;
      if ((state == S_HALT) && start) begin
        pc      <= '0;
        retired <= '0;
      end else if (retire) begin
        pc <= pc + PC_W'(1);
        if (retired != {RET_W{1'b1}}) retired <= retired + RET_W'(1);
      end
    end
  end

endmodule
